regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 32×32 register file among several writeback requesters (ALU, load unit, CSR unit) using round-robin arbitration with valid/ready handshakes. It registers the winning write onto the register-file write port. It also keeps a busy scoreboard of destination registers with outstanding writes, so the issue stage can stall on hazards. The block sits between the execute/memory units and the register file.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_if.sv | 16 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and writeback source ids
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_CSR = 2'd2
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - packed writeback request/grant bundle
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = XLEN
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_rd;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    modport master (output req_valid, req_rd, req_data, input req_ready);
    modport slave  (input req_valid, req_rd, req_data, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; pointer moves past the winner on advance
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [N-1:0]     upper;
    logic [N-1:0]     sel;

    // Requests at or above the pointer take precedence; otherwise wrap to the lowest.
    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = req[i] && (PTR_W'(i) >= ptr);
        end
        sel     = (|upper) ? upper : req;
        grant   = sel & ~(sel - N'(1));
        ptr_nxt = ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                ptr_nxt = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_nxt;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write port arbiter with busy scoreboard; REGFILE_WB_BYPASS_EN adds forwarding
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = XLEN
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_arbiter_if.slave wb,
    output logic                rf_reg_write,
    output logic [ADDR_W-1:0]   rf_rd,
    output logic [DATA_W-1:0]   rf_rd_data,
    input  logic                sb_set_valid,
    input  logic [ADDR_W-1:0]   sb_set_rd,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic [ADDR_W-1:0]   rs2,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                rs1_fwd_valid,
    output logic                rs2_fwd_valid,
    output logic [DATA_W-1:0]   rs1_fwd_data,
    output logic [DATA_W-1:0]   rs2_fwd_data,
`endif
    output logic                rs1_busy,
    output logic                rs2_busy
);
    localparam int NREGS = 1 << ADDR_W;

    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic [ADDR_W-1:0]  win_rd;
    logic [DATA_W-1:0]  win_data;
    logic [NREGS-1:0]   busy;
    logic [NREGS-1:0]   busy_nxt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (wb.req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign wb.req_ready = grant;
    assign accept       = |grant;

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_rd   = wb.req_rd[i*ADDR_W +: ADDR_W];
                win_data = wb.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // x0 writes complete the handshake but never assert the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_reg_write <= 1'b0;
            rf_rd        <= '0;
            rf_rd_data   <= '0;
        end else if (accept) begin
            rf_reg_write <= (win_rd != '0);
            rf_rd        <= win_rd;
            rf_rd_data   <= win_data;
        end else begin
            rf_reg_write <= 1'b0;
        end
    end

    // Set is applied after clear so a newly dispatched producer keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (rf_reg_write) begin
            busy_nxt[rf_rd] = 1'b0;
        end
        if (sb_set_valid && (sb_set_rd != '0)) begin
            busy_nxt[sb_set_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign rs1_fwd_valid = rf_reg_write && (rf_rd == rs1) && (rs1 != '0);
    assign rs2_fwd_valid = rf_reg_write && (rf_rd == rs2) && (rs2 != '0);
    assign rs1_fwd_data  = rf_rd_data;
    assign rs2_fwd_data  = rf_rd_data;
    assign rs1_busy      = busy[rs1] && !rs1_fwd_valid;
    assign rs2_busy      = busy[rs2] && !rs2_fwd_valid;
`else
    assign rs1_busy      = busy[rs1];
    assign rs2_busy      = busy[rs2];
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and random checks against a reference model
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rf_reg_write;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_rd_data;
    logic          sb_set_valid;
    logic [AW-1:0] sb_set_rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          rs1_busy;
    logic          rs2_busy;
`ifdef REGFILE_WB_BYPASS_EN
    logic          rs1_fwd_valid;
    logic          rs2_fwd_valid;
    logic [DW-1:0] rs1_fwd_data;
    logic [DW-1:0] rs2_fwd_data;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) wb_if ();

    regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb           (wb_if),
        .rf_reg_write (rf_reg_write),
        .rf_rd        (rf_rd),
        .rf_rd_data   (rf_rd_data),
        .sb_set_valid (sb_set_valid),
        .sb_set_rd    (sb_set_rd),
        .rs1          (rs1),
        .rs2          (rs2),
`ifdef REGFILE_WB_BYPASS_EN
        .rs1_fwd_valid(rs1_fwd_valid),
        .rs2_fwd_valid(rs2_fwd_valid),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_data (rs2_fwd_data),
`endif
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          v[N];
    int          rd_in[N];
    logic [31:0] d_in[N];
    int          ptr_m;
    bit          busy_m[32];
    bit          we_m;
    int          rd_m;
    logic [31:0] data_m;
    int          last_win;

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ptr_m = 0; we_m = 0; rd_m = 0; data_m = '0; last_win = -1;
        for (int i = 0; i < 32; i++) busy_m[i] = 0;
        for (int i = 0; i < N; i++) begin
            v[i] = 0; rd_in[i] = 0; d_in[i] = '0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            wb_if.req_valid[i]              = v[i];
            wb_if.req_rd[i*AW +: AW]        = AW'(rd_in[i]);
            wb_if.req_data[i*DW +: DW]      = d_in[i];
        end
    endtask

    task automatic check_and_advance();
        int         win;
        logic [N-1:0] exp_ready;
        bit         f1, f2;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr_m + k) % N;
            if (win < 0 && v[idx]) win = idx;
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        expect_eq("req_ready", wb_if.req_ready, exp_ready);
        expect_eq("rf_reg_write", rf_reg_write, we_m);
        expect_eq("rf_rd", rf_rd, rd_m);
        expect_eq("rf_rd_data", rf_rd_data, data_m);
`ifdef REGFILE_WB_BYPASS_EN
        f1 = we_m && (rd_m == int'(rs1)) && (rs1 != 0);
        f2 = we_m && (rd_m == int'(rs2)) && (rs2 != 0);
        expect_eq("rs1_fwd_valid", rs1_fwd_valid, f1);
        expect_eq("rs2_fwd_valid", rs2_fwd_valid, f2);
        if (f1) expect_eq("rs1_fwd_data", rs1_fwd_data, data_m);
        if (f2) expect_eq("rs2_fwd_data", rs2_fwd_data, data_m);
`else
        f1 = 0;
        f2 = 0;
`endif
        expect_eq("rs1_busy", rs1_busy, busy_m[rs1] && !f1);
        expect_eq("rs2_busy", rs2_busy, busy_m[rs2] && !f2);
        if (we_m) busy_m[rd_m] = 0;
        if (sb_set_valid && sb_set_rd != 0) busy_m[sb_set_rd] = 1;
        last_win = win;
        if (win >= 0) begin
            ptr_m  = (win + 1) % N;
            we_m   = (rd_in[win] != 0);
            rd_m   = rd_in[win];
            data_m = d_in[win];
            v[win] = 0;
        end else begin
            we_m = 0;
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic tick();
        drive();
        #1;
        check_and_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_set_valid = 0; sb_set_rd = '0; rs1 = '0; rs2 = '0;
        model_reset();
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        sb_set_valid = 0; sb_set_rd = '0; rs1 = '0; rs2 = '0;
        model_reset();
        drive();
        @(negedge clk);
        do_reset();

        // Reset state
        expect_eq("reset_rf_we", rf_reg_write, 0);
        expect_eq("reset_rf_rd", rf_rd, 0);
        expect_eq("reset_rf_data", rf_rd_data, 0);
        tick();

        // Single ALU request
        v[WB_ALU] = 1; rd_in[WB_ALU] = 5; d_in[WB_ALU] = 32'hDEADBEEF;
        tick();
        expect_eq("single_we", rf_reg_write, 1);
        expect_eq("single_rd", rf_rd, 5);
        expect_eq("single_data", rf_rd_data, 32'hDEADBEEF);
        tick();

        // Contention from reset: 0,1,2,0,1,2
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = 1; rd_in[i] = 10 + i; d_in[i] = 32'h100 + i;
            end
            tick();
            expect_eq("contention_order", last_win, k % N);
        end
        for (int i = 0; i < N; i++) v[i] = 0;
        tick();

        // x0 write from LSU with an unrelated busy bit present
        sb_set_valid = 1; sb_set_rd = 4; rs1 = 4;
        tick();
        sb_set_valid = 0;
        v[WB_LSU] = 1; rd_in[WB_LSU] = 0; d_in[WB_LSU] = 32'hCAFE;
        tick();
        expect_eq("x0_we", rf_reg_write, 0);
        expect_eq("x0_busy_kept", rs1_busy, 1);
        tick();

        // Scoreboard set, clear, and set-wins-over-clear
        rs1 = 7; sb_set_valid = 1; sb_set_rd = 7;
        tick();
        sb_set_valid = 0;
        expect_eq("sb_set_busy", rs1_busy, 1);
        tick();
        v[WB_CSR] = 1; rd_in[WB_CSR] = 7; d_in[WB_CSR] = 32'h77;
        tick();
        tick();
        expect_eq("sb_clear_busy", rs1_busy, 0);
        sb_set_valid = 1; sb_set_rd = 7;
        tick();
        sb_set_valid = 0;
        v[WB_CSR] = 1; rd_in[WB_CSR] = 7; d_in[WB_CSR] = 32'h78;
        tick();
        sb_set_valid = 1; sb_set_rd = 7;
        tick();
        sb_set_valid = 0;
        expect_eq("sb_set_wins", rs1_busy, 1);
        tick();

`ifdef REGFILE_WB_BYPASS_EN
        rs2 = 9; sb_set_valid = 1; sb_set_rd = 9;
        tick();
        sb_set_valid = 0;
        v[WB_ALU] = 1; rd_in[WB_ALU] = 9; d_in[WB_ALU] = 32'h1234;
        tick();
        expect_eq("byp_fwd_valid", rs2_fwd_valid, 1);
        expect_eq("byp_fwd_data", rs2_fwd_data, 32'h1234);
        expect_eq("byp_busy", rs2_busy, 0);
        tick();
`endif

        // Reset while a write to rd=3 is being accepted
        sb_set_valid = 1; sb_set_rd = 3; rs1 = 3;
        tick();
        sb_set_valid = 0;
        v[WB_LSU] = 1; rd_in[WB_LSU] = 3; d_in[WB_LSU] = 32'h33;
        drive();
        #1;
        check_and_advance();
        #2;
        rst_n = 1'b0;
        model_reset();
        drive();
        @(negedge clk);
        expect_eq("rst_mid_we", rf_reg_write, 0);
        expect_eq("rst_mid_busy", rs1_busy, 0);
        rst_n = 1'b1;
        rs1 = 3;
        for (int i = 0; i < N; i++) begin
            v[i] = 1; rd_in[i] = 20 + i; d_in[i] = 32'h200 + i;
        end
        drive();
        #1;
        expect_eq("rst_mid_ptr", wb_if.req_ready, 3'b001);
        check_and_advance();
        @(negedge clk);

        // Randomized traffic; unaccepted requesters hold their payload
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i]) begin
                    v[i]     = ($urandom_range(0, 99) < 55);
                    rd_in[i] = $urandom_range(0, 7);
                    d_in[i]  = $urandom;
                end
            end
            sb_set_valid = ($urandom_range(0, 99) < 40);
            sb_set_rd    = AW'($urandom_range(0, 7));
            rs1          = AW'($urandom_range(0, 7));
            rs2          = AW'($urandom_range(0, 7));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
